// File: rtl/ifir_poly_interp.sv
// ----------------------------------------------------------------------------
// ifir_poly_interp
// Polyphase interpolating FIR. Every input sample starts a sweep of L
// branches. Each branch is one output sample on clock_up, so an input
// stream at 1/L of the clock rate gives a gapless output stream.
// Branch p uses coefficients h[p], h[p+L], ..., h[p+L*(TAPS-1)].
//
// Optional feature: define IFIR_POLY_SAT_EN to saturate the scaled result to
// the DW-bit signed range. Without it, the result wraps to its low DW bits.
//
// Ports:
//   clock_up  - output-rate clock
//   rstn      - asynchronous active-low reset
//   en        - global advance enable; 0 freezes every register
//   in_valid  - single-cycle strobe; data_in holds a new sample
//   data_in   - signed input sample (DW bits)
//   clr       - clears the sticky underrun/overrun flags
//   data_out  - signed interpolated sample (DW bits)
//   out_valid - data_out was updated on the last edge
//   phase     - branch index of the current data_out
//   underrun  - sticky: a sweep ended and no new sample had arrived
//   overrun   - sticky: a new sample arrived before the sweep completed
// ----------------------------------------------------------------------------
module ifir_poly_interp #(
   parameter int DW    = 24,
   parameter int CW    = 28,
   parameter int L     = 8,
   parameter int TAPS  = 4,
   parameter int SHIFT = 10,
   // Default is a zero-order hold: h[j] = 2^SHIFT for j < L, otherwise 0.
   parameter logic [L*TAPS*CW-1:0] COEFS = (L*TAPS*CW)'({L{CW'(64'd1 << SHIFT)}})
) (
   input  logic                    clock_up,
   input  logic                    rstn,
   input  logic                    en,
   input  logic                    in_valid,
   input  logic signed [DW-1:0]    data_in,
   input  logic                    clr,
   output logic signed [DW-1:0]    data_out,
   output logic                    out_valid,
   output logic [$clog2(L)-1:0]    phase,
   output logic                    underrun,
   output logic                    overrun
);

   localparam int PW = $clog2(L);
   localparam int AW = DW + CW + $clog2(TAPS);

   logic signed [DW-1:0] xQ [TAPS];
   logic signed [DW-1:0] xD [TAPS];
   logic [PW-1:0]        phQ, phD;
   logic                 runningQ, runningD;
   logic signed [DW-1:0] dataOutQ, dataOutD;
   logic                 outValidQ, outValidD;
   logic [PW-1:0]        phaseQ, phaseD;
   logic                 underrunQ, underrunD;
   logic                 overrunQ, overrunD;

   logic signed [CW-1:0] coef;
   logic signed [AW-1:0] acc;
   logic signed [AW-1:0] shifted;
   logic signed [DW-1:0] yOut;
   logic                 lastBranch;

   // Branch ph of the dot product over the delay line as it stands before
   // any shift. Operands are sign-extended to the full accumulator width,
   // so every product and the running sum are exact.
   always_comb begin
      acc  = '0;
      coef = '0;
      for (int k = 0; k < TAPS; k++) begin
         coef = COEFS[(int'(phQ) + L*k)*CW +: CW];
         acc  = acc + AW'(xQ[k]) * AW'(coef);
      end
   end

   // Scale down by SHIFT; the arithmetic shift rounds toward minus
   // infinity. The result then either saturates or wraps to DW bits.
   always_comb begin
      shifted = acc >>> SHIFT;
`ifdef IFIR_POLY_SAT_EN
      if (shifted[AW-1:DW-1] != {(AW-DW+1){shifted[AW-1]}}) begin
         yOut = shifted[AW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      end else begin
         yOut = shifted[DW-1:0];
      end
`else
      yOut = DW'(shifted);
`endif
   end

   // Sweep control. A running sweep emits branch ph on every edge. A new
   // sample always restarts at branch 0, which drops any branches left in
   // the current sweep. A sweep with no new sample after branch L-1 stops,
   // and data_out holds its last value. Flag set events win over clr.
   always_comb begin
      xD        = xQ;
      phD       = phQ;
      runningD  = runningQ;
      dataOutD  = dataOutQ;
      outValidD = 1'b0;
      phaseD    = phaseQ;
      lastBranch = (phQ == PW'(L-1));

      if (runningQ) begin
         dataOutD  = yOut;
         phaseD    = phQ;
         outValidD = 1'b1;
      end

      if (in_valid) begin
         for (int k = TAPS-1; k > 0; k--) begin
            xD[k] = xQ[k-1];
         end
         xD[0]    = data_in;
         phD      = '0;
         runningD = 1'b1;
      end else if (runningQ) begin
         if (lastBranch) begin
            phD      = '0;
            runningD = 1'b0;
         end else begin
            phD = phQ + PW'(1);
         end
      end

      underrunD = (underrunQ & ~clr) | (runningQ & lastBranch & ~in_valid);
      overrunD  = (overrunQ & ~clr) | (runningQ & ~lastBranch & in_valid);
   end

   // All state advances only while en is high; with en low every register,
   // out_valid included, keeps its value.
   always_ff @(posedge clock_up or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < TAPS; k++) begin
            xQ[k] <= '0;
         end
         phQ       <= '0;
         runningQ  <= 1'b0;
         dataOutQ  <= '0;
         outValidQ <= 1'b0;
         phaseQ    <= '0;
         underrunQ <= 1'b0;
         overrunQ  <= 1'b0;
      end else if (en) begin
         xQ        <= xD;
         phQ       <= phD;
         runningQ  <= runningD;
         dataOutQ  <= dataOutD;
         outValidQ <= outValidD;
         phaseQ    <= phaseD;
         underrunQ <= underrunD;
         overrunQ  <= overrunD;
      end
   end

   assign data_out  = dataOutQ;
   assign out_valid = outValidQ;
   assign phase     = phaseQ;
   assign underrun  = underrunQ;
   assign overrun   = overrunQ;

endmodule

// File: tb/tb_ifir_poly_interp.sv
// ----------------------------------------------------------------------------
// tb_ifir_poly_interp
// Bench for ifir_poly_interp. The main instance uses the default zero-order
// hold coefficients and is tracked cycle by cycle against a sample-history
// model. A second instance with custom coefficients covers multi-tap sums,
// floor rounding and the saturate/wrap configuration.
// ----------------------------------------------------------------------------
module tb_ifir_poly_interp;

   localparam int DW    = 24;
   localparam int CW    = 28;
   localparam int L     = 8;
   localparam int TAPS  = 4;
   localparam int SHIFT = 10;
   localparam int PW    = $clog2(L);

   // Custom set: h[0]=2^14, h[1]=-512, h[9]=1024, all others zero.
   function automatic logic [L*TAPS*CW-1:0] makeSatCoefs();
      logic [L*TAPS*CW-1:0] v;
      v = '0;
      v[0*CW +: CW] = CW'(16384);
      v[1*CW +: CW] = CW'(-512);
      v[9*CW +: CW] = CW'(1024);
      return v;
   endfunction

   localparam logic [L*TAPS*CW-1:0] SAT_COEFS = makeSatCoefs();

   logic                 clock_up = 1'b0;
   logic                 rstn     = 1'b1;
   logic                 en       = 1'b0;
   logic                 in_valid = 1'b0;
   logic signed [DW-1:0] data_in  = '0;
   logic                 clr      = 1'b0;
   logic                 satValid = 1'b0;
   logic signed [DW-1:0] satData  = '0;

   logic signed [DW-1:0] dataOut;
   logic                 outValid;
   logic [PW-1:0]        phaseO;
   logic                 underrunO;
   logic                 overrunO;

   logic signed [DW-1:0] satOut;
   logic                 satOutValid;
   logic [PW-1:0]        satPhase;
   logic                 satUnder;
   logic                 satOver;

   int checks   = 0;
   int failures = 0;

   ifir_poly_interp #(.DW(DW), .CW(CW), .L(L), .TAPS(TAPS), .SHIFT(SHIFT)) dut (
      .clock_up (clock_up),
      .rstn     (rstn),
      .en       (en),
      .in_valid (in_valid),
      .data_in  (data_in),
      .clr      (clr),
      .data_out (dataOut),
      .out_valid(outValid),
      .phase    (phaseO),
      .underrun (underrunO),
      .overrun  (overrunO)
   );

   ifir_poly_interp #(.DW(DW), .CW(CW), .L(L), .TAPS(TAPS), .SHIFT(SHIFT),
                      .COEFS(SAT_COEFS)) satDut (
      .clock_up (clock_up),
      .rstn     (rstn),
      .en       (en),
      .in_valid (satValid),
      .data_in  (satData),
      .clr      (clr),
      .data_out (satOut),
      .out_valid(satOutValid),
      .phase    (satPhase),
      .underrun (satUnder),
      .overrun  (satOver)
   );

   always #5 clock_up = ~clock_up;

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // ---------------- behavioural model of the main instance ----------------
   longint               hist[$];
   int                   mPh       = 0;
   bit                   mRun      = 1'b0;
   logic signed [DW-1:0] mDataOut  = '0;
   bit                   mOutValid = 1'b0;
   int                   mPhase    = 0;
   bit                   mUnder    = 1'b0;
   bit                   mOver     = 1'b0;

   function automatic longint defaultCoef(input int j);
      return (j < L) ? (longint'(1) << SHIFT) : 0;
   endfunction

   always @(posedge clock_up or negedge rstn) begin : model
      longint acc;
      bit     last;
      if (!rstn) begin
         hist.delete();
         for (int k = 0; k < TAPS; k++) hist.push_back(0);
         mPh = 0; mRun = 0; mDataOut = '0; mOutValid = 0;
         mPhase = 0; mUnder = 0; mOver = 0;
      end else if (en) begin
         last = (mPh == L-1);
         if (mRun) begin
            acc = 0;
            for (int k = 0; k < TAPS; k++) acc += defaultCoef(mPh + L*k) * hist[k];
            mDataOut  = DW'(acc >>> SHIFT);
            mPhase    = mPh;
            mOutValid = 1;
         end else begin
            mOutValid = 0;
         end
         if (clr) begin
            mUnder = 0;
            mOver  = 0;
         end
         if (mRun && last && !in_valid) mUnder = 1;
         if (mRun && !last && in_valid) mOver = 1;
         if (in_valid) begin
            hist.push_front(longint'(data_in));
            void'(hist.pop_back());
            mPh  = 0;
            mRun = 1;
         end else if (mRun) begin
            if (last) begin
               mPh  = 0;
               mRun = 0;
            end else begin
               mPh++;
            end
         end
      end
   end

   // Every cycle, on the falling edge, the main instance must match the model.
   always @(negedge clock_up) begin
      checkOutput("cmpDataOut",  longint'(dataOut),   longint'(mDataOut));
      checkOutput("cmpOutValid", longint'(outValid),  longint'(mOutValid));
      checkOutput("cmpPhase",    longint'(phaseO),    longint'(mPhase));
      checkOutput("cmpUnderrun", longint'(underrunO), longint'(mUnder));
      checkOutput("cmpOverrun",  longint'(overrunO),  longint'(mOver));
   end

   // One clock edge with the given inputs; returns just after the edge.
   task automatic applyStimulus(input logic v, input logic signed [DW-1:0] d,
                                input logic e, input logic c);
      in_valid = v;
      data_in  = d;
      en       = e;
      clr      = c;
      @(posedge clock_up);
      #1;
   endtask

   initial begin
      #2 rstn = 1'b0;
      @(posedge clock_up);
      @(posedge clock_up);
      #1;
      checkOutput("rstDataOut",  dataOut,   0);
      checkOutput("rstOutValid", outValid,  0);
      checkOutput("rstPhase",    phaseO,    0);
      checkOutput("rstUnderrun", underrunO, 0);
      checkOutput("rstOverrun",  overrunO,  0);

      // Idle after release: nothing may move.
      rstn = 1'b1;
      for (int i = 0; i < 20; i++) applyStimulus(0, 0, 1, 0);
      checkOutput("idleDataOut",  dataOut,   0);
      checkOutput("idleOutValid", outValid,  0);
      checkOutput("idleUnderrun", underrunO, 0);

      // Custom-coefficient instance: saturation/wrap, multi-tap, floor.
      satValid = 1'b1;
      satData  = 24'sh400000;
      applyStimulus(0, 0, 1, 0);
      satValid = 1'b0;
      applyStimulus(0, 0, 1, 0);
`ifdef IFIR_POLY_SAT_EN
      checkOutput("satPhase0", satOut, 8388607);
`else
      checkOutput("wrapPhase0", satOut, 0);
`endif
      checkOutput("satValid0", satOutValid, 1);
      applyStimulus(0, 0, 1, 0);
      checkOutput("satPhase1Val", satOut, -2097152);
      checkOutput("satPhase1Idx", satPhase, 1);
      satValid = 1'b1;
      satData  = 3;
      applyStimulus(0, 0, 1, 0);
      satValid = 1'b0;
      checkOutput("satOverrun", satOver, 1);
      applyStimulus(0, 0, 1, 0);
      checkOutput("satSecondPh0", satOut, 48);
      applyStimulus(0, 0, 1, 0);
      checkOutput("satFloorTap", satOut, 4194302);

      // Zero-order hold with back-to-back samples: gapless 1000 then 4000.
      applyStimulus(1, 1000, 1, 0);
      for (int i = 0; i < L; i++) begin
         applyStimulus(i == L-1, (i == L-1) ? 4000 : 0, 1, 0);
         checkOutput("zohFirstVal", dataOut, 1000);
         checkOutput("zohFirstPh",  phaseO,  i);
         checkOutput("zohFirstOv",  outValid, 1);
      end
      for (int i = 0; i < L; i++) begin
         applyStimulus(0, 0, 1, 0);
         checkOutput("zohSecondVal", dataOut, 4000);
         checkOutput("zohSecondPh",  phaseO,  i);
         checkOutput("zohSecondOv",  outValid, 1);
      end
      applyStimulus(0, 0, 1, 0);
      checkOutput("zohEndOv",   outValid, 0);
      checkOutput("zohEndHold", dataOut, 4000);
      applyStimulus(0, 0, 1, 1);
      checkOutput("zohClr", underrunO, 0);

      // Single sample, then underrun.
      applyStimulus(1, -5, 1, 0);
      for (int i = 0; i < L; i++) begin
         applyStimulus(0, 0, 1, 0);
         checkOutput("undVal", dataOut, -5);
         checkOutput("undPh",  phaseO, i);
      end
      applyStimulus(0, 0, 1, 0);
      checkOutput("undOv",   outValid, 0);
      checkOutput("undHold", dataOut, -5);
      checkOutput("undFlag", underrunO, 1);
      checkOutput("undNoOvr", overrunO, 0);
      applyStimulus(0, 0, 1, 1);
      checkOutput("undClr", underrunO, 0);

      // Early second sample: phases 0,1,2 then restart at 0.
      applyStimulus(1, 7, 1, 0);
      applyStimulus(0, 0, 1, 0);
      checkOutput("ovrPh0", phaseO, 0);
      applyStimulus(0, 0, 1, 0);
      checkOutput("ovrPh1", phaseO, 1);
      applyStimulus(1, 9, 1, 0);
      checkOutput("ovrPh2",   phaseO, 2);
      checkOutput("ovrVal2",  dataOut, 7);
      checkOutput("ovrFlag",  overrunO, 1);
      applyStimulus(0, 0, 1, 0);
      checkOutput("ovrRestartPh",  phaseO, 0);
      checkOutput("ovrRestartVal", dataOut, 9);
      for (int i = 0; i < L; i++) applyStimulus(0, 0, 1, 0);
      applyStimulus(0, 0, 1, 1);
      checkOutput("ovrClr", overrunO, 0);

      // Freeze mid-sweep with en=0, then resume at the next branch.
      applyStimulus(1, 100, 1, 0);
      for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 0);
      checkOutput("frzPh3", phaseO, 3);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, 0, 0, 0);
         checkOutput("frzPh",  phaseO, 3);
         checkOutput("frzVal", dataOut, 100);
         checkOutput("frzOv",  outValid, 1);
      end
      applyStimulus(0, 0, 1, 0);
      checkOutput("frzResume", phaseO, 4);

      // Reset pulse mid-sweep, then restart from branch 0.
      rstn = 1'b0;
      #1;
      checkOutput("midRstVal", dataOut, 0);
      checkOutput("midRstOv",  outValid, 0);
      checkOutput("midRstPh",  phaseO, 0);
      applyStimulus(0, 0, 1, 0);
      rstn = 1'b1;
      applyStimulus(1, 200, 1, 0);
      applyStimulus(0, 0, 1, 0);
      checkOutput("postRstPh",  phaseO, 0);
      checkOutput("postRstVal", dataOut, 200);
      checkOutput("postRstOv",  outValid, 1);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0);

      @(posedge clock_up);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
